// File: rtl/sat_pkg.sv
// Shared limits and operation encoding for the saturating arithmetic blocks.
package sat_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest representable value for the given width and signedness.
  function automatic longint sat_max(input int width, input bit is_signed);
    if (is_signed)
      return (64'sd1 <<< (width - 1)) - 64'sd1;
    else
      return (64'sd1 <<< width) - 64'sd1;
  endfunction

  // Smallest representable value for the given width and signedness.
  function automatic longint sat_min(input int width, input bit is_signed);
    if (is_signed)
      return -(64'sd1 <<< (width - 1));
    else
      return 64'sd0;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational saturating adder/subtractor: y = clamp(a +/- b) with
// separate flags for clamping at the top and bottom of the range.
module sat_clamp
  import sat_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y,
  output logic             ovf_hi,
  output logic             ovf_lo
);

  // Two guard bits hold any sum or difference of two WIDTH-bit operands exactly.
  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] MAX_E = EW'(sat_max(WIDTH, SIGNED != 0));
  localparam logic signed [EW-1:0] MIN_E = EW'(sat_min(WIDTH, SIGNED != 0));
  localparam logic [WIDTH-1:0] MAX_W = MAX_E[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_W = MIN_E[WIDTH-1:0];

  logic signed [EW-1:0] ea;
  logic signed [EW-1:0] eb;
  logic signed [EW-1:0] r;

  // Extend both operands, form the exact result, then clamp to the range.
  always_comb begin
    if (SIGNED != 0) begin
      ea = {{2{a[WIDTH-1]}}, a};
      eb = {{2{b[WIDTH-1]}}, b};
    end else begin
      ea = {2'b00, a};
      eb = {2'b00, b};
    end
    r      = sub ? (ea - eb) : (ea + eb);
    ovf_hi = (r > MAX_E);
    ovf_lo = (r < MIN_E);
    if (ovf_hi)
      y = MAX_W;
    else if (ovf_lo)
      y = MIN_W;
    else
      y = r[WIDTH-1:0];
  end

endmodule

// File: rtl/sat_accumulator.sv
// Registered saturating accumulator with clamp pulse, sticky range flags
// and a saturating count of clamped updates.
module sat_accumulator
  import sat_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SIGNED    = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_sub,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     acc,
  output logic                 sat_evt,
  output logic                 sat_hi,
  output logic                 sat_lo,
  output logic [CNT_WIDTH-1:0] sat_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] nxt_acc;
  logic             ovf_hi;
  logic             ovf_lo;

  sat_clamp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_clamp (
    .a      (acc),
    .b      (in_data),
    .sub    (in_sub == OP_SUB),
    .y      (nxt_acc),
    .ovf_hi (ovf_hi),
    .ovf_lo (ovf_lo)
  );

  // Accumulator, flags and counter; clear wins over a same-cycle sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      sat_evt   <= 1'b0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
      sat_cnt   <= '0;
    end else if (clr) begin
      acc       <= '0;
      out_valid <= 1'b0;
      sat_evt   <= 1'b0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
      sat_cnt   <= '0;
    end else if (in_valid) begin
      acc       <= nxt_acc;
      out_valid <= 1'b1;
      sat_evt   <= ovf_hi | ovf_lo;
      sat_hi    <= sat_hi | ovf_hi;
      sat_lo    <= sat_lo | ovf_lo;
      if ((ovf_hi || ovf_lo) && (sat_cnt != CNT_MAX))
        sat_cnt <= sat_cnt + CNT_WIDTH'(1);
    end else begin
      out_valid <= 1'b0;
      sat_evt   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench: two accumulator instances (4-bit unsigned with a 2-bit
// counter, 8-bit signed) checked against an integer reference model.
module tb_sat_accumulator;

  localparam int AW = 4, AS = 0, AC = 2;
  localparam int BW = 8, BS = 1, BC = 8;

  typedef struct {
    longint acc;
    bit     evt;
    bit     hi;
    bit     lo;
    longint cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          a_clr = 0, a_valid = 0, a_sub = 0;
  logic [AW-1:0] a_data = '0;
  logic          a_out_valid, a_evt, a_hi, a_lo;
  logic [AW-1:0] a_acc;
  logic [AC-1:0] a_cnt;

  logic          b_clr = 0, b_valid = 0, b_sub = 0;
  logic [BW-1:0] b_data = '0;
  logic          b_out_valid, b_evt, b_hi, b_lo;
  logic [BW-1:0] b_acc;
  logic [BC-1:0] b_cnt;

  int total = 0;
  int bad   = 0;

  exp_t qa[$];
  exp_t qb[$];

  longint ma_acc = 0, ma_cnt = 0;
  bit     ma_hi = 0, ma_lo = 0;
  longint mb_acc = 0, mb_cnt = 0;
  bit     mb_hi = 0, mb_lo = 0;

  sat_accumulator #(.WIDTH(AW), .SIGNED(AS), .CNT_WIDTH(AC)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_valid), .in_sub(a_sub),
    .in_data(a_data), .out_valid(a_out_valid), .acc(a_acc), .sat_evt(a_evt),
    .sat_hi(a_hi), .sat_lo(a_lo), .sat_cnt(a_cnt)
  );

  sat_accumulator #(.WIDTH(BW), .SIGNED(BS), .CNT_WIDTH(BC)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_valid), .in_sub(b_sub),
    .in_data(b_data), .out_valid(b_out_valid), .acc(b_acc), .sat_evt(b_evt),
    .sat_hi(b_hi), .sat_lo(b_lo), .sat_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic on the value the operand represents,
  // then clamp to the numeric range of the given width/signedness.
  task automatic model_step(input int w, input bit sgn, input int cw,
                            input bit sub, input longint raw,
                            inout longint acc, inout bit hi, inout bit lo,
                            inout longint cnt, output exp_t e);
    longint mx, mn, d, r, cmax;
    bit evt;
    if (sgn) begin
      mx = (64'sd1 <<< (w - 1)) - 1;
      mn = -(64'sd1 <<< (w - 1));
      d  = (((raw >>> (w - 1)) & 1) != 0) ? raw - (64'sd1 <<< w) : raw;
    end else begin
      mx = (64'sd1 <<< w) - 1;
      mn = 0;
      d  = raw;
    end
    cmax = (64'sd1 <<< cw) - 1;
    r = sub ? acc - d : acc + d;
    evt = 0;
    if (r > mx) begin
      acc = mx; hi = 1; evt = 1;
    end else if (r < mn) begin
      acc = mn; lo = 1; evt = 1;
    end else begin
      acc = r;
    end
    if (evt && cnt < cmax) cnt++;
    e.acc = acc & ((64'sd1 <<< w) - 1);
    e.evt = evt;
    e.hi  = hi;
    e.lo  = lo;
    e.cnt = cnt;
  endtask

  task automatic set_a(input bit v, input bit s, input longint d, input bit c);
    exp_t e;
    a_valid = v; a_sub = s; a_data = AW'(d); a_clr = c;
    if (c) begin
      ma_acc = 0; ma_hi = 0; ma_lo = 0; ma_cnt = 0;
    end else if (v) begin
      model_step(AW, AS != 0, AC, s, d, ma_acc, ma_hi, ma_lo, ma_cnt, e);
      qa.push_back(e);
    end
  endtask

  task automatic set_b(input bit v, input bit s, input longint d, input bit c);
    exp_t e;
    b_valid = v; b_sub = s; b_data = BW'(d); b_clr = c;
    if (c) begin
      mb_acc = 0; mb_hi = 0; mb_lo = 0; mb_cnt = 0;
    end else if (v) begin
      model_step(BW, BS != 0, BC, s, d, mb_acc, mb_hi, mb_lo, mb_cnt, e);
      qb.push_back(e);
    end
  endtask

  task automatic a1(input bit v, input bit s, input longint d, input bit c);
    set_a(v, s, d, c);
    set_b(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic b1(input bit v, input bit s, input longint d, input bit c);
    set_a(0, 0, 0, 0);
    set_b(v, s, d, c);
    @(negedge clk);
  endtask

  task automatic models_reset();
    ma_acc = 0; ma_hi = 0; ma_lo = 0; ma_cnt = 0;
    mb_acc = 0; mb_hi = 0; mb_lo = 0; mb_cnt = 0;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_a_acc"}, longint'(a_acc), 0);
    chk({tag, "_a_valid"}, longint'(a_out_valid), 0);
    chk({tag, "_a_evt"}, longint'(a_evt), 0);
    chk({tag, "_a_hi"}, longint'(a_hi), 0);
    chk({tag, "_a_lo"}, longint'(a_lo), 0);
    chk({tag, "_a_cnt"}, longint'(a_cnt), 0);
  endtask

  // Monitor: every presented output must match the oldest expected result.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (a_out_valid) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_acc", longint'(a_acc), e.acc);
        chk("a_evt", longint'(a_evt), longint'(e.evt));
        chk("a_hi", longint'(a_hi), longint'(e.hi));
        chk("a_lo", longint'(a_lo), longint'(e.lo));
        chk("a_cnt", longint'(a_cnt), e.cnt);
      end
    end else begin
      chk("a_evt_without_valid", longint'(a_evt), 0);
    end
    if (b_out_valid) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_acc", longint'(b_acc), e.acc);
        chk("b_evt", longint'(b_evt), longint'(e.evt));
        chk("b_hi", longint'(b_hi), longint'(e.hi));
        chk("b_lo", longint'(b_lo), longint'(e.lo));
        chk("b_cnt", longint'(b_cnt), e.cnt);
      end
    end else begin
      chk("b_evt_without_valid", longint'(b_evt), 0);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_a_zero("reset");
    chk("reset_b_acc", longint'(b_acc), 0);
    chk("reset_b_cnt", longint'(b_cnt), 0);
    rst = 1'b0;
    models_reset();

    // Unsigned 4-bit: plain adds, clamp high, sticky hold, clamp low, exact limit.
    a1(1, 0, 5, 0);
    a1(1, 0, 6, 0);
    a1(1, 0, 4, 0);
    a1(1, 0, 1, 0);
    a1(1, 1, 3, 0);
    a1(0, 0, 0, 1);
    chk_a_zero("clr1");
    a1(1, 0, 2, 0);
    a1(1, 1, 5, 0);
    a1(1, 1, 0, 0);

    // Counter saturation at 3, then clear with a same-cycle sample dropped.
    a1(0, 0, 0, 1);
    a1(1, 0, 15, 0);
    for (int i = 0; i < 5; i++) a1(1, 0, 15, 0);
    a1(1, 0, 7, 1);
    chk_a_zero("clr_drop");
    a1(0, 0, 0, 0);
    chk("clr_drop_a_acc_hold", longint'(a_acc), 0);

    // Signed 8-bit: clamp at +127, subtracting -128 from 0, then back to 0.
    b1(1, 0, 100, 0);
    b1(1, 0, 100, 0);
    b1(0, 0, 0, 1);
    chk("b_clr_acc", longint'(b_acc), 0);
    chk("b_clr_hi", longint'(b_hi), 0);
    b1(1, 1, 8'h80, 0);
    b1(1, 1, 127, 0);
    b1(1, 0, 8'h9C, 0);
    b1(1, 0, 8'h9C, 0);
    b1(1, 1, 29, 0);

    // Asynchronous reset between edges with a sample waiting to be taken.
    a1(0, 0, 0, 1);
    a1(1, 0, 9, 0);
    a_valid = 1; a_sub = 0; a_data = 4'd4; a_clr = 0;
    #2 rst = 1'b1;
    #1;
    chk_a_zero("async_rst");
    chk("async_rst_b_acc", longint'(b_acc), 0);
    @(negedge clk);
    rst = 1'b0;
    models_reset();
    a1(1, 0, 4, 0);
    a1(0, 0, 0, 0);

    // Randomised traffic on both instances with occasional clears and gaps.
    for (int i = 0; i < 400; i++) begin
      set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            longint'($urandom_range(0, 15)), $urandom_range(0, 23) == 0);
      set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            longint'($urandom_range(0, 255)), $urandom_range(0, 23) == 0);
      @(negedge clk);
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("a_queue_drained", longint'(qa.size()), 0);
    chk("b_queue_drained", longint'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
# sat_accumulator

Parametrised saturating accumulator, the sequential successor to the team's 4-bit saturating adder. It adds or subtracts a stream of operands into a registered accumulator and clamps at the representable limits, in unsigned or two's-complement mode. It reports per-sample saturation pulses, sticky overflow/underflow flags and a saturating event counter. It sits after sample sources that need a bounded running sum: DSP integrators, level meters and credit counters.

## Interface
- WIDTH, 4: operand and accumulator width in bits, 2..32.
- SIGNED, 0: 0 = unsigned range, 1 = two's-complement range.
- CNT_WIDTH, 8: width of the saturation event counter.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of accumulator, flags and counter.
- in_valid  input  1  operand present this cycle.
- in_sub  input  1  0 = acc + in_data, 1 = acc − in_data; sampled with in_valid.
- in_data  input  WIDTH  operand, interpreted per SIGNED.
- out_valid  output  1  acc updated by the previous accepted sample.
- acc  output  WIDTH  accumulator value.
- sat_evt  output  1  one-cycle pulse, aligned with out_valid, when the last update clamped.
- sat_hi  output  1  sticky: clamped at MAX since last clr/rst.
- sat_lo  output  1  sticky: clamped at MIN since last clr/rst.
- sat_cnt  output  CNT_WIDTH  number of clamped updates, saturating at all-ones.

## Operation
- Limits: unsigned MAX = 2^WIDTH−1, MIN = 0. Signed MAX = 2^(WIDTH−1)−1, MIN = −2^(WIDTH−1).
- Arithmetic: extend acc and in_data to WIDTH+2 bits (zero-extend if unsigned, sign-extend if signed). Compute the raw result r = acc ± in_data exactly.
- Clamp rules:
  - r > MAX → acc ← MAX; set sat_hi; pulse sat_evt.
  - r < MIN → acc ← MIN; set sat_lo; pulse sat_evt.
  - Otherwise acc ← r[WIDTH−1:0].
  - A result exactly equal to MAX or MIN is not a saturation.
- sat_cnt increments on every sat_evt and holds at 2^CNT_WIDTH−1 without wrapping.
- Per-cycle priority: rst > clr > in_valid > hold.
  - clr: acc, sat_hi, sat_lo, sat_cnt ← 0; out_valid, sat_evt ← 0. An in_valid sample in the same cycle is dropped.
  - No in_valid: acc, sticky flags and counter hold; out_valid and sat_evt go to 0.
- No backpressure: one sample is accepted every cycle in_valid is high.

## Timing
- Reset values: acc = 0, out_valid = 0, sat_evt = 0, sat_hi = 0, sat_lo = 0, sat_cnt = 0. Reset takes effect immediately and asynchronously.
- A reset asserted mid-stream discards any in-flight sample. The first sample accepted after rst deasserts is added to 0.
- Latency is 1 cycle: a sample accepted at edge N gives acc, out_valid and sat_evt valid after edge N. Sticky flags and sat_cnt update at the same edge.
- Throughput is one sample per cycle. Back-to-back samples each see the acc produced by the preceding sample.
- The combinational path from acc through the add and clamp back to acc must close in one cycle at WIDTH = 32.

## Structure
- Shared package sat_pkg holds:
  - the functions sat_max(WIDTH, SIGNED) and sat_min(WIDTH, SIGNED);
  - the operation encoding constants OP_ADD = 0 and OP_SUB = 1.
- One sub-module, sat_clamp: combinational and parametrised on WIDTH and SIGNED.
  - Inputs: a, b, sub.
  - Outputs: y, ovf_hi, ovf_lo.
  - It is the generalised saturating adder/subtractor. sat_accumulator instantiates it once and adds the registers, clear logic, flags and counter.

## Test plan
- WIDTH=4, SIGNED=0, acc=0: add 5, then add 6 → acc=5, then acc=11; sat_evt=0; sat_cnt=0.
- WIDTH=4, SIGNED=0, acc=15: add 1 → acc=15, sat_evt pulses one cycle, sat_hi=1, sat_cnt=1. Then subtract 3 → acc=12, sat_hi stays 1.
- WIDTH=4, SIGNED=0, acc=2: subtract 5 → acc=0, sat_lo=1. Then subtract 0 → acc=0, sat_evt=0 (exact limit, no clamp).
- WIDTH=8, SIGNED=1, acc=100: add 100 → acc=127, sat_hi=1. Clear, then subtract −128 (0x80) from 0 → acc=127, sat_hi=1. Then subtract 127 → acc=0.
- CNT_WIDTH=2, WIDTH=4 unsigned, acc=15: five consecutive add 15 → sat_cnt counts 1, 2, 3, 3, 3. Then clr with in_valid=1 in the same cycle → acc=0, all flags and counter 0, sample dropped.
- Assert rst asynchronously between edges during a stream at acc=9 → all outputs 0 immediately. After release, add 4 → acc=4.
